remote_cmd_seq: RTL and testbench

Parametrised command sequencer that drives a RemoteComm-style UART command/response interface from a queue of pre-loaded commands. Each entry pairs a 16-bit command with the number of intermediate 0x5A step acknowledges to expect before the final 0xA5. The block replaces hand-sequenced command/ack checking in bench and bring-up harnesses. It sits between a loader (bench or host) and the RemoteComm instance that talks to KnightsTour.

---
 rtl/remote_cmd_seq_pkg.sv | 23 ++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/remote_cmd_seq.sv | 188 ++++++++++++++++++
 tb/tb_remote_cmd_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_cmd_seq_pkg.sv
// rtl/remote_cmd_seq_pkg.sv - shared types and default ack bytes for remote_cmd_seq
package remote_cmd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_NEXT,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_BAD_BYTE = 2'd2,
        ERR_SHORT    = 2'd3
    } err_code_t;

    localparam logic [7:0] ACK_FINAL_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_STEP_DEFAULT  = 8'h5A;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command queue FIFO with push/pop/flush and occupancy count
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/remote_cmd_seq.sv
// rtl/remote_cmd_seq.sv - queued RemoteComm command/ack sequencer; define REMOTE_CMD_SEQ_RETRY_EN
// to re-send an entry once after its first response timeout.
module remote_cmd_seq
    import remote_cmd_seq_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter int         STEP_W       = 5,
    parameter int         TIMEOUT_CLKS = 1_000_000,
    parameter logic [7:0] ACK_FINAL    = ACK_FINAL_DEFAULT,
    parameter logic [7:0] ACK_STEP     = ACK_STEP_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                push_cmd,
    input  logic [STEP_W-1:0]          push_steps,
    input  logic                       start,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       snd_cmd,
    output logic [15:0]                cmd,
    input  logic                       cmd_snt,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [STEP_W-1:0]          steps_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int EW = 16 + STEP_W;
    localparam logic [TW-1:0]     T_LOAD   = TW'(TIMEOUT_CLKS);
    localparam logic [TW-1:0]     T_ONE    = 1;
    localparam logic [STEP_W-1:0] STEP_ONE = 1;
    localparam logic [AW-1:0]     IDX_ONE  = 1;

    state_t            state;
    err_code_t         pend_code;
    logic [TW-1:0]     timer;
    logic [STEP_W-1:0] cur_steps;
    logic [AW-1:0]     entry_idx;
    logic [EW-1:0]     head;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    logic              retry_used;
`endif

    assign busy       = (state != S_IDLE);
    assign fifo_push  = push && (state == S_IDLE);
    assign fifo_flush = (state == S_ERR);
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    // A retried entry is already out of the queue; re-send it from cmd/cur_steps.
    assign fifo_pop   = (state == S_SEND) && !retry_used;
`else
    assign fifo_pop   = (state == S_SEND);
`endif

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({push_steps, push_cmd}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pend_code  <= ERR_NONE;
            timer      <= '0;
            cur_steps  <= '0;
            entry_idx  <= '0;
            snd_cmd    <= 1'b0;
            cmd        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            fail_idx   <= '0;
            steps_seen <= '0;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
            retry_used <= 1'b0;
`endif
        end else begin
            snd_cmd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !fifo_empty) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                        fail_idx  <= '0;
                        entry_idx <= '0;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                        retry_used <= 1'b0;
`endif
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                    if (!retry_used) begin
                        cmd       <= head[15:0];
                        cur_steps <= head[EW-1:16];
                    end
`else
                    cmd       <= head[15:0];
                    cur_steps <= head[EW-1:16];
`endif
                    snd_cmd    <= 1'b1;
                    steps_seen <= '0;
                    state      <= S_WAIT_SNT;
                end
                S_WAIT_SNT: begin
                    if (cmd_snt) begin
                        timer <= T_LOAD;
                        state <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    // A response in the expiry cycle takes priority over the timeout.
                    if (resp_rdy) begin
                        if (resp == ACK_STEP && steps_seen < cur_steps) begin
                            steps_seen <= steps_seen + STEP_ONE;
                            timer      <= T_LOAD;
                        end else if (resp == ACK_FINAL && steps_seen == cur_steps) begin
                            state <= S_NEXT;
                        end else if (resp == ACK_FINAL) begin
                            pend_code <= ERR_SHORT;
                            state     <= S_ERR;
                        end else begin
                            pend_code <= ERR_BAD_BYTE;
                            state     <= S_ERR;
                        end
                    end else if (timer == T_ONE) begin
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                        if (!retry_used) begin
                            retry_used <= 1'b1;
                            state      <= S_SEND;
                        end else begin
                            pend_code <= ERR_TIMEOUT;
                            state     <= S_ERR;
                        end
`else
                        pend_code <= ERR_TIMEOUT;
                        state     <= S_ERR;
`endif
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_NEXT: begin
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        entry_idx <= entry_idx + IDX_ONE;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                        retry_used <= 1'b0;
`endif
                        state     <= S_SEND;
                    end
                end
                S_ERR: begin
                    err      <= 1'b1;
                    err_code <= pend_code;
                    fail_idx <= entry_idx;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb/tb_remote_cmd_seq.sv - self-checking bench for remote_cmd_seq with a scripted responder
module tb_remote_cmd_seq;
    import remote_cmd_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int STEP_W = 5;
    localparam int TMO = 120;
    localparam logic [7:0] AF = ACK_FINAL_DEFAULT;
    localparam logic [7:0] AS = ACK_STEP_DEFAULT;

    logic        clk = 1'b0;
    logic        rst, push, start, cmd_snt, resp_rdy;
    logic [15:0] push_cmd;
    logic [4:0]  push_steps;
    logic [7:0]  resp;
    logic        full, snd_cmd, busy, done, err;
    logic [3:0]  count;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [2:0]  fail_idx;
    logic [4:0]  steps_seen;

    int tests_run = 0;
    int tests_failed = 0;
    int snd_total = 0;

    logic [15:0] e_cmd [8];
    int          e_steps [8];
    logic [7:0]  scr [8][40];
    int          scr_len [8];
    int          n_ent;

    bit m_err;
    int m_code, m_idx, m_steps, m_sent;

    remote_cmd_seq #(
        .DEPTH        (DEPTH),
        .STEP_W       (STEP_W),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_cmd   (push_cmd),
        .push_steps (push_steps),
        .start      (start),
        .full       (full),
        .count      (count),
        .snd_cmd    (snd_cmd),
        .cmd        (cmd),
        .cmd_snt    (cmd_snt),
        .resp_rdy   (resp_rdy),
        .resp       (resp),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .fail_idx   (fail_idx),
        .steps_seen (steps_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (snd_cmd) snd_total++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_entry(input logic [15:0] c, input int s);
        push = 1'b1; push_cmd = c; push_steps = 5'(s);
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_snt();
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
    endtask

    task automatic pulse_resp(input logic [7:0] b);
        resp = b; resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
    endtask

    task automatic wait_snd(output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (snd_cmd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_good(input int e, input logic [15:0] c, input int s);
        e_cmd[e] = c; e_steps[e] = s;
        for (int b = 0; b < s; b++) scr[e][b] = AS;
        scr[e][s] = AF;
        scr_len[e] = s + 1;
    endtask

    task automatic gen_entry(input int e);
        int s, k, kind;
        logic [7:0] junk;
        s = $urandom_range(0, 6);
        kind = $urandom_range(0, 5);
        set_good(e, 16'($urandom), s);
        if (kind == 1 && s > 0) begin
            k = $urandom_range(0, s - 1);
            for (int b = 0; b < k; b++) scr[e][b] = AS;
            scr[e][k] = AF;
            scr_len[e] = k + 1;
        end else if (kind == 2) begin
            k = $urandom_range(0, s);
            junk = 8'($urandom);
            if (junk == AF || junk == AS) junk = 8'h00;
            if (k == s && $urandom_range(0, 1) == 1) junk = AS;
            for (int b = 0; b < k; b++) scr[e][b] = AS;
            scr[e][k] = junk;
            scr_len[e] = k + 1;
        end
    endtask

    // Outcome of a whole sequence, judged byte by byte from the protocol rules.
    task automatic model();
        int seen;
        m_err = 1'b0; m_code = 0; m_idx = 0; m_steps = 0; m_sent = 0;
        for (int e = 0; e < n_ent; e++) begin
            m_sent = e + 1;
            seen = 0;
            for (int b = 0; b < scr_len[e]; b++) begin
                if (scr[e][b] == AS && seen < e_steps[e]) begin
                    seen++;
                end else if (scr[e][b] == AF && seen == e_steps[e]) begin
                    break;
                end else begin
                    m_err = 1'b1;
                    m_code = (scr[e][b] == AF) ? 3 : 2;
                    m_idx = e;
                    break;
                end
            end
            m_steps = seen;
            if (m_err) break;
        end
    endtask

    task automatic run_seq(input int first_delay);
        int base, n;
        logic [3:0] c;
        bit ok;
        for (int e = 0; e < n_ent; e++) push_entry(e_cmd[e], e_steps[e]);
        chk("count_loaded", count, n_ent);
        model();
        base = snd_total;
        pulse_start();
        for (int e = 0; e < m_sent; e++) begin
            wait_snd(n, ok);
            chk("snd_seen", ok, 1);
            if (!ok) break;
            chk("snd_latency", n, (e == 0) ? 1 : 2);
            chk("cmd", cmd, e_cmd[e]);
            if (e == 0) begin
                c = count;
                push_entry(16'hDEAD, 3);
                chk("push_while_busy", count, c);
            end
            if ($urandom_range(0, 2) == 0) pulse_resp(AF);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pulse_snt();
            for (int b = 0; b < scr_len[e]; b++) begin
                repeat ((b == 0) ? first_delay : $urandom_range(0, 6)) @(negedge clk);
                pulse_resp(scr[e][b]);
            end
            if (!(m_err && e == m_sent - 1)) chk("steps_after_entry", steps_seen, e_steps[e]);
        end
        wait_idle(ok);
        chk("idle", ok, 1);
        chk("done", done, !m_err);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        chk("fail_idx", fail_idx, m_idx);
        chk("steps_seen", steps_seen, m_steps);
        chk("count_end", count, 0);
        chk("snd_count", snd_total - base, m_sent);
    endtask

    initial begin
        int n;
        bit ok;
        rst = 1'b1; push = 1'b0; start = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0;
        push_cmd = '0; push_steps = '0; resp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_snd", snd_cmd, 0);
        chk("rst_code", err_code, 0);

        pulse_start();
        repeat (3) @(negedge clk);
        chk("start_empty_busy", busy, 0);

        n_ent = 1; set_good(0, 16'h2000, 0);
        run_seq(100);

        n_ent = 2; set_good(0, 16'h7020, 24); set_good(1, 16'h2000, 0);
        run_seq(3);

        n_ent = 1; set_good(0, 16'h1111, 2);
        scr[0][0] = AS; scr[0][1] = AF; scr_len[0] = 2;
        run_seq(2);

        n_ent = 3; set_good(0, 16'h0A01, 1); set_good(1, 16'h0A02, 0); set_good(2, 16'h0A03, 2);
        scr[1][0] = 8'h33; scr_len[1] = 1;
        run_seq(2);

        for (int it = 0; it < 20; it++) begin
            n_ent = $urandom_range(1, 4);
            for (int e = 0; e < n_ent; e++) gen_entry(e);
            run_seq($urandom_range(0, 10));
        end

        // Silent responder: response timeout.
        push_entry(16'h1234, 1);
        pulse_start();
        wait_snd(n, ok);
        chk("tmo_snd", ok, 1);
        pulse_snt();
        repeat (TMO) @(negedge clk);
        chk("tmo_not_early", err, 0);
        chk("tmo_busy", busy, 1);
        @(negedge clk);
`ifdef REMOTE_CMD_SEQ_RETRY_EN
        chk("retry_snd", snd_cmd, 1);
        chk("retry_cmd", cmd, 16'h1234);
        chk("retry_err", err, 0);
        @(negedge clk);
        pulse_snt();
        repeat (TMO) @(negedge clk);
        chk("retry_not_early", err, 0);
        @(negedge clk);
`endif
        chk("tmo_err", err, 1);
        chk("tmo_code", err_code, 1);
        chk("tmo_idx", fail_idx, 0);
        chk("tmo_count", count, 0);

        // Overfill the queue, then reset mid-sequence.
        for (int i = 0; i <= DEPTH; i++) push_entry(16'h0100 + 16'(i), 0);
        chk("full", full, 1);
        chk("count_full", count, DEPTH);
        pulse_start();
        wait_snd(n, ok);
        chk("fifo_head", cmd, 16'h0100);
        pulse_snt();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_full", full, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
